// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// prbs_checker : self-synchronising PRBS checker, flywheel predictor, rev 1.0
// ============================================================================
module prbs_checker #(
    parameter int unsigned       DEPTH      = 8,
    parameter logic [DEPTH-1:0]  COEFFS     = 8'hB8,
    parameter int unsigned       LOCK_COUNT = 16,
    parameter int unsigned       WIN_LEN    = 256,
    parameter int unsigned       ERR_LIMIT  = 16,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned FILL_W  = $clog2(DEPTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WPOS_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [DEPTH-1:0]   TOP_BIT    = {1'b1, {(DEPTH-1){1'b0}}};
    localparam logic [DEPTH-1:0]   TAPS       = COEFFS | TOP_BIT;
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(DEPTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WPOS_W-1:0]  WPOS_LAST  = WPOS_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  WERR_MAX   = WERR_W'(ERR_LIMIT);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [DEPTH-1:0]   history;   // history[k] = bit seen k+1 enables ago
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match_cnt;
    logic [WPOS_W-1:0]  win_pos;
    logic [WERR_W-1:0]  win_err;

    logic              pred;
    logic              mismatch;
    logic [WERR_W-1:0] win_err_inc;
    logic              limit_hit;
    logic [CNT_W-1:0]  err_count_sat;
    logic [CNT_W-1:0]  bit_count_sat;

    assign pred          = ^(history & TAPS);
    assign mismatch      = in_bit ^ pred;
    assign win_err_inc   = win_err + 1'b1;
    assign limit_hit     = mismatch && (win_err_inc == WERR_MAX);
    assign err_count_sat = (err_count == '1) ? err_count : err_count + 1'b1;
    assign bit_count_sat = (bit_count == '1) ? bit_count : bit_count + 1'b1;
    assign locked        = (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            history   <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            if (enable) begin
                if (state == HUNT) begin
                    history <= {history[DEPTH-2:0], in_bit};
                    if (fill != FILL_FULL) begin
                        fill <= fill + 1'b1;
                    end else if (!mismatch && (history != '0)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state     <= LOCKED;
                            match_cnt <= '0;
                            win_pos   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    // Flywheel: the predictor feeds itself so a flipped bit is counted once.
                    history   <= {history[DEPTH-2:0], pred};
                    err_pulse <= mismatch;
                    if (limit_hit) begin
                        state     <= HUNT;
                        lock_lost <= 1'b1;
                        fill      <= '0;
                        match_cnt <= '0;
                        win_pos   <= '0;
                        win_err   <= '0;
                    end else if (win_pos == WPOS_LAST) begin
                        win_pos <= '0;
                        win_err <= '0;
                    end else begin
                        win_pos <= win_pos + 1'b1;
                        if (mismatch) begin
                            win_err <= win_err_inc;
                        end
                    end
                end
            end
            if (clear) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (enable && (state == LOCKED)) begin
                bit_count <= bit_count_sat;
                if (mismatch) begin
                    err_count <= err_count_sat;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// tb_prbs_checker : vectors, directed sequences and random stimulus vs model
// ============================================================================
module tb_prbs_checker;

    localparam int DEPTH   = 8;
    localparam int LOCKN   = 16;
    localparam int WINL    = 256;
    localparam int ELIM    = 16;
    localparam longint MAX_BIG   = 64'hFFFF_FFFF;
    localparam longint MAX_SMALL = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        in_bit = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse, lock_lost;
    logic [31:0] err_count, bit_count;
    logic        s_locked, s_err_pulse, s_lock_lost;
    logic [3:0]  s_err_count, s_bit_count;

    prbs_checker #(.DEPTH(DEPTH), .COEFFS(8'hB8), .LOCK_COUNT(LOCKN), .WIN_LEN(WINL),
                   .ERR_LIMIT(ELIM), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
        .err_count(err_count), .bit_count(bit_count));

    // Narrow-counter copy so saturation is reachable.
    prbs_checker #(.DEPTH(DEPTH), .COEFFS(8'hB8), .LOCK_COUNT(LOCKN), .WIN_LEN(WINL),
                   .ERR_LIMIT(ELIM), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .clear(clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .lock_lost(s_lock_lost),
        .err_count(s_err_count), .bit_count(s_bit_count));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [7:0] taps = 8'hB8 | 8'h80;

    // Transmit-side PRBS: each new bit is the XOR of tapped past bits.
    int gen_hist[$];
    // Reference checker state.
    int     m_hist[$];
    int     m_fill, m_match, m_wpos, m_werr;
    bit     m_locked, m_pulse, m_lost;
    longint m_errc, m_bitc;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic longint min_l(longint a, longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic int gen_next();
        int b = 0;
        for (int k = 0; k < DEPTH; k++) b ^= (taps[k] & gen_hist[k]);
        gen_hist.push_front(b);
        void'(gen_hist.pop_back());
        return b;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int k = 0; k < DEPTH; k++) m_hist.push_back(0);
        m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        m_locked = 0; m_pulse = 0; m_lost = 0; m_errc = 0; m_bitc = 0;
    endfunction

    function automatic void model_step(bit en, bit b, bit clr);
        int p = 0;
        int any = 0;
        m_pulse = 0;
        m_lost  = 0;
        if (en) begin
            for (int k = 0; k < DEPTH; k++) begin
                p   ^= (taps[k] & m_hist[k]);
                any |= m_hist[k];
            end
            if (!m_locked) begin
                if (m_fill < DEPTH) m_fill++;
                else if (b == p && any != 0) begin
                    m_match++;
                    if (m_match == LOCKN) begin
                        m_locked = 1; m_match = 0; m_wpos = 0; m_werr = 0;
                    end
                end else m_match = 0;
                m_hist.push_front(b);
            end else begin
                m_bitc++;
                if (b != p) begin
                    m_pulse = 1; m_errc++; m_werr++;
                end
                if (m_werr == ELIM) begin
                    m_locked = 0; m_lost = 1; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                    if (m_wpos == WINL) begin m_wpos = 0; m_werr = 0; end
                end
                m_hist.push_front(p);
            end
            void'(m_hist.pop_back());
        end
        if (clr) begin m_errc = 0; m_bitc = 0; end
    endfunction

    task automatic check_all();
        check("locked",          locked,      m_locked);
        check("err_pulse",       err_pulse,   m_pulse);
        check("lock_lost",       lock_lost,   m_lost);
        check("err_count",       err_count,   min_l(m_errc, MAX_BIG));
        check("bit_count",       bit_count,   min_l(m_bitc, MAX_BIG));
        check("small_err_count", s_err_count, min_l(m_errc, MAX_SMALL));
        check("small_bit_count", s_bit_count, min_l(m_bitc, MAX_SMALL));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(bit en, bit b, bit clr);
        enable = en; in_bit = b; clear = clr;
        @(posedge clk);
        model_step(en, b, clr);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send(bit en, bit flip, bit clr);
        bit b;
        if (en) b = 1'(gen_next()) ^ flip;
        else    b = 1'($urandom_range(0, 1));
        tick(en, b, clr);
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit en; bit flip; bit clr;
        bit exp_locked; bit exp_pulse; bit exp_lost;
        int exp_errc; int exp_bitc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen_lock;
        bit [7:0] seed = 8'h5A;
        for (int k = 0; k < DEPTH; k++) gen_hist.push_back(int'(seed[k]));

        tbl[0] = '{1, 0, 0, 1, 0, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 1, 0, 0, 0, 1};
        tbl[2] = '{1, 1, 0, 1, 1, 0, 1, 2};
        tbl[3] = '{1, 0, 0, 1, 0, 0, 1, 3};
        tbl[4] = '{1, 1, 1, 1, 1, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 1, 0, 0, 0, 1};
        tbl[6] = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 1, 1, 0, 1, 1};

        // Reset state
        @(negedge clk);
        apply_reset();
        check("rst_locked",    locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_bit_count", bit_count, 0);

        // Lock after 8 fill + 16 matches, then 1000 clean bits
        for (int i = 1; i <= 24; i++) begin
            send(1, 0, 0);
            check("lock_timing", locked, (i == 24));
        end
        repeat (1000) send(1, 0, 0);
        check("clean_err_count", err_count, 0);
        check("clean_bit_count", bit_count, 1000);

        // Vector table: single errors, gaps, clear interplay
        send(0, 0, 1);
        foreach (tbl[i]) begin
            send(tbl[i].en, tbl[i].flip, tbl[i].clr);
            check("vec_locked",    locked,    tbl[i].exp_locked);
            check("vec_err_pulse", err_pulse, tbl[i].exp_pulse);
            check("vec_lock_lost", lock_lost, tbl[i].exp_lost);
            check("vec_err_count", err_count, tbl[i].exp_errc);
            check("vec_bit_count", bit_count, tbl[i].exp_bitc);
        end

        // 16-bit error burst loses lock, then relock after 24 clean bits
        apply_reset();
        repeat (24) send(1, 0, 0);
        check("relock_a", locked, 1);
        for (int i = 1; i <= 16; i++) begin
            send(1, 1, 0);
            check("burst_pulse",     err_pulse, 1);
            check("burst_lock_lost", lock_lost, (i == 16));
            check("burst_locked",    locked,    (i != 16));
        end
        check("burst_err_count", err_count, 16);
        for (int i = 1; i <= 24; i++) begin
            send(1, 0, 0);
            check("relock_timing", locked, (i == 24));
        end

        // Asynchronous reset mid-lock, with err_pulse high beforehand
        send(1, 1, 0);
        check("pre_rst_pulse", err_pulse, 1);
        #2 reset = 1'b1;
        #1;
        check("async_locked",    locked, 0);
        check("async_err_pulse", err_pulse, 0);
        check("async_lock_lost", lock_lost, 0);
        check("async_err_count", err_count, 0);
        check("async_bit_count", bit_count, 0);
        check("async_small_cnt", s_err_count, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // All-zero stream never locks
        seen_lock = 0;
        repeat (500) begin
            tick(1, 0, 0);
            if (locked) seen_lock = 1;
        end
        check("zero_never_locked", seen_lock, 0);
        check("zero_err_count",    err_count, 0);

        // Random 50% enable on a clean stream
        repeat (600) send(1'($urandom_range(0, 1)), 0, 0);
        check("gappy_locked",    locked, 1);
        check("gappy_err_count", err_count, 0);

        // Randomised error rates against the reference model
        for (int blk = 0; blk < 12; blk++) begin
            int rate = blk % 4;
            repeat (400) begin
                bit en   = ($urandom_range(0, 3) != 0);
                bit clr  = ($urandom_range(0, 149) == 0);
                bit flip;
                case (rate)
                    0:       flip = 0;
                    1:       flip = ($urandom_range(0, 63) == 0);
                    2:       flip = ($urandom_range(0, 7) == 0);
                    default: flip = ($urandom_range(0, 1) == 0);
                endcase
                send(en, flip, clr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
